// File: rtl/tlp_lane_dispatcher.sv
// rtl/tlp_lane_dispatcher.sv - routes upstream TLP words to four lane FIFOs by destination field
// Honours per-lane pause/continue hold and error_full from the lane flow-control FSM.
module tlp_lane_dispatcher #(
  parameter int unsigned DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            pause,
  input  logic [3:0]            cont,
  input  logic [3:0]            error_full,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [3:0]            push,
  output logic [3:0]            hold,
  output logic                  idle,
  output logic                  err
);

  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            hold_q, hold_d;
  logic                  v_q, v_d;
  logic                  p_q, p_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            dest;

  assign dest = data_q[DATA_WIDTH-1:DATA_WIDTH-2];

  always_comb begin
    push = 4'b0000;
    if (state_q == S_ACTIVE && v_q && !hold_q[dest]) begin
      push[dest] = 1'b1;
    end
  end

  // A new read may only be issued once the stage is free or draining this cycle.
  always_comb begin
    fifo_pop = (state_q == S_ACTIVE) && !fifo_empty && !p_q && (!v_q || (push != 4'b0000));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   state_d = S_IDLE;
      S_IDLE:   if (!fifo_empty) state_d = S_ACTIVE;
      S_ACTIVE: if (fifo_empty && !v_q && !p_q) state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RESET;
    endcase
    if (state_q != S_RESET && error_full != 4'b0000) begin
      state_d = S_ERROR;
    end
    if (init) begin
      state_d = S_INIT;
    end
  end

  always_comb begin
    hold_d = hold_q;
    v_d    = v_q;
    p_d    = fifo_pop;
    data_d = data_q;
    if (state_q == S_IDLE || state_q == S_ACTIVE) begin
      hold_d = (hold_q | pause) & ~cont;
    end
    if (push != 4'b0000) begin
      v_d = 1'b0;
    end
    // Read data landing while already in ERROR is dropped so the staged word stays put.
    if (p_q && state_q == S_ACTIVE) begin
      v_d    = 1'b1;
      data_d = fifo_data;
    end
    if (init) begin
      hold_d = 4'b0000;
      v_d    = 1'b0;
      p_d    = 1'b0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RESET;
      hold_q  <= 4'b0000;
      v_q     <= 1'b0;
      p_q     <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      v_q     <= v_d;
      p_q     <= p_d;
      data_q  <= data_d;
    end
  end

  assign out_data = data_q;
  assign hold     = hold_q;
  assign idle     = (state_q == S_IDLE);
  assign err      = (state_q == S_ERROR);

endmodule

// File: tb/tb_tlp_lane_dispatcher.sv
// tb/tb_tlp_lane_dispatcher.sv - directed self-checking bench for tlp_lane_dispatcher
module tb_tlp_lane_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] pause;
  logic [3:0] cont;
  logic [3:0] error_full;
  logic       fifo_empty;
  logic [5:0] fifo_data = 6'd0;
  logic       fifo_pop;
  logic [5:0] out_data;
  logic [3:0] push;
  logic [3:0] hold;
  logic       idle;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Upstream FIFO model with one-cycle read latency.
  logic [5:0] mem [0:15];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_pop) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 4'd1;
    end
  end

  always #5 clk = ~clk;

  tlp_lane_dispatcher #(.DATA_WIDTH(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .pause      (pause),
    .cont       (cont),
    .error_full (error_full),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .out_data   (out_data),
    .push       (push),
    .hold       (hold),
    .idle       (idle),
    .err        (err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input logic [5:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic wait_push(input int max_cycles, output logic found);
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      tick();
      if (push != 4'b0000) found = 1'b1;
    end
  endtask

  task automatic wait_idle(input int max_cycles, output logic found);
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      tick();
      if (idle) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b0; pause = 4'b0; cont = 4'b0; error_full = 4'b0;
    repeat (2) tick();
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b expected 0", idle); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (push !== 4'b0000) begin errors++; $display("FAIL reset_push: got %b expected 0000", push); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", fifo_pop); end
    checks++; if (out_data !== 6'd0) begin errors++; $display("FAIL reset_out_data: got %b expected 000000", out_data); end
    checks++; if (hold !== 4'b0000) begin errors++; $display("FAIL reset_hold: got %b expected 0000", hold); end
    reset = 1'b1;
    tick();
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL boot_init_idle: got %b expected 0", idle); end
    checks++; if (push !== 4'b0000 || fifo_pop !== 1'b0) begin errors++; $display("FAIL boot_init_strobes: got push=%b pop=%b expected 0000/0", push, fifo_pop); end
    tick();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL boot_idle: got %b expected 1", idle); end
    checks++; if (push !== 4'b0000 || fifo_pop !== 1'b0) begin errors++; $display("FAIL boot_idle_strobes: got push=%b pop=%b expected 0000/0", push, fifo_pop); end
  endtask

  task automatic test_routing();
    logic [3:0] exp_push [3];
    logic [5:0] exp_data [3];
    int         pop_cyc [3];
    int         k;
    int         npops;
    exp_push[0] = 4'b0001; exp_data[0] = 6'b00_0101;
    exp_push[1] = 4'b0100; exp_data[1] = 6'b10_1111;
    exp_push[2] = 4'b1000; exp_data[2] = 6'b11_0001;
    k = 0; npops = 0;
    for (int i = 0; i < 3; i++) put(exp_data[i]);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (fifo_pop) begin
        if (npops < 3) pop_cyc[npops] = c;
        npops++;
      end
      if (push != 4'b0000) begin
        if (k < 3) begin
          checks++; if (push !== exp_push[k]) begin errors++; $display("FAIL route_push%0d: got %b expected %b", k, push, exp_push[k]); end
          checks++; if (out_data !== exp_data[k]) begin errors++; $display("FAIL route_data%0d: got %b expected %b", k, out_data, exp_data[k]); end
        end
        k++;
      end
    end
    checks++; if (k != 3) begin errors++; $display("FAIL route_push_count: got %0d expected 3", k); end
    checks++; if (npops != 3) begin errors++; $display("FAIL route_pop_count: got %0d expected 3", npops); end
    if (npops >= 3) begin
      checks++; if (pop_cyc[1] - pop_cyc[0] != 2 || pop_cyc[2] - pop_cyc[1] != 2) begin
        errors++; $display("FAIL route_pop_spacing: got %0d,%0d expected 2,2", pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1]);
      end
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL route_back_idle: got %b expected 1", idle); end
  endtask

  task automatic test_pause();
    logic found;
    pause = 4'b0100;
    tick();
    pause = 4'b0000;
    checks++; if (hold !== 4'b0100) begin errors++; $display("FAIL pause_hold_set: got %b expected 0100", hold); end
    put(6'b10_0011);
    put(6'b00_0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (push !== 4'b0000) begin errors++; $display("FAIL pause_stall_push: got %b expected 0000", push); end
    end
    checks++; if (out_data !== 6'b10_0011) begin errors++; $display("FAIL pause_staged_data: got %b expected 100011", out_data); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL pause_hol_pop: got %b expected 0", fifo_pop); end
    cont = 4'b0100;
    checks++; if (push !== 4'b0000) begin errors++; $display("FAIL pause_cont_same_cycle: got %b expected 0000", push); end
    tick();
    cont = 4'b0000;
    checks++; if (push !== 4'b0100) begin errors++; $display("FAIL pause_release_push: got %b expected 0100", push); end
    checks++; if (out_data !== 6'b10_0011) begin errors++; $display("FAIL pause_release_data: got %b expected 100011", out_data); end
    checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL pause_release_pop: got %b expected 1", fifo_pop); end
    wait_push(10, found);
    checks++; if (!found || push !== 4'b0001 || out_data !== 6'b00_0001) begin
      errors++; $display("FAIL pause_next_word: got found=%b push=%b data=%b expected 1/0001/000001", found, push, out_data);
    end
    wait_idle(10, found);
    checks++; if (!found) begin errors++; $display("FAIL pause_back_idle: got %b expected 1", idle); end
  endtask

  task automatic test_simultaneous();
    logic found;
    pause = 4'b0010;
    tick();
    pause = 4'b0000;
    checks++; if (hold !== 4'b0010) begin errors++; $display("FAIL simul_hold_set: got %b expected 0010", hold); end
    pause = 4'b0010; cont = 4'b0010;
    tick();
    pause = 4'b0000; cont = 4'b0000;
    checks++; if (hold !== 4'b0000) begin errors++; $display("FAIL simul_cont_wins: got %b expected 0000", hold); end
    put(6'b01_0000);
    wait_push(10, found);
    checks++; if (!found || push !== 4'b0010 || out_data !== 6'b01_0000) begin
      errors++; $display("FAIL simul_push: got found=%b push=%b data=%b expected 1/0010/010000", found, push, out_data);
    end
    wait_idle(10, found);
    checks++; if (!found) begin errors++; $display("FAIL simul_back_idle: got %b expected 1", idle); end
  endtask

  task automatic test_error();
    logic found;
    pause = 4'b1000;
    tick();
    pause = 4'b0000;
    put(6'b11_0110);
    put(6'b00_0010);
    repeat (6) tick();
    checks++; if (out_data !== 6'b11_0110 || push !== 4'b0000) begin
      errors++; $display("FAIL err_pre_staged: got data=%b push=%b expected 110110/0000", out_data, push);
    end
    error_full = 4'b0001;
    tick();
    error_full = 4'b0000;
    checks++; if (err !== 1'b1 || idle !== 1'b0) begin errors++; $display("FAIL err_enter: got err=%b idle=%b expected 1/0", err, idle); end
    cont = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (push !== 4'b0000 || fifo_pop !== 1'b0) begin
        errors++; $display("FAIL err_strobes: got push=%b pop=%b expected 0000/0", push, fifo_pop);
      end
      checks++; if (err !== 1'b1 || out_data !== 6'b11_0110 || hold !== 4'b1000) begin
        errors++; $display("FAIL err_held: got err=%b data=%b hold=%b expected 1/110110/1000", err, out_data, hold);
      end
    end
    init = 1'b1; cont = 4'b0000;
    tick();
    init = 1'b0;
    checks++; if (err !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL err_init_state: got err=%b idle=%b expected 0/0", err, idle); end
    checks++; if (hold !== 4'b0000 || out_data !== 6'd0) begin errors++; $display("FAIL err_init_clear: got hold=%b data=%b expected 0000/000000", hold, out_data); end
    tick();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL err_init_idle: got %b expected 1", idle); end
    wait_push(10, found);
    checks++; if (!found || push !== 4'b0001 || out_data !== 6'b00_0010) begin
      errors++; $display("FAIL err_after_init_word: got found=%b push=%b data=%b expected 1/0001/000010", found, push, out_data);
    end
    wait_idle(10, found);
    checks++; if (!found) begin errors++; $display("FAIL err_back_idle: got %b expected 1", idle); end
  endtask

  task automatic test_reset_stall();
    pause = 4'b1000;
    tick();
    pause = 4'b0000;
    put(6'b11_1010);
    repeat (6) tick();
    checks++; if (out_data !== 6'b11_1010 || push !== 4'b0000 || hold !== 4'b1000) begin
      errors++; $display("FAIL rst_stall_pre: got data=%b push=%b hold=%b expected 111010/0000/1000", out_data, push, hold);
    end
    reset = 1'b0;
    tick();
    checks++; if (hold !== 4'b0000 || out_data !== 6'd0 || push !== 4'b0000 || fifo_pop !== 1'b0) begin
      errors++; $display("FAIL rst_stall_clear: got hold=%b data=%b push=%b pop=%b expected 0000/000000/0000/0", hold, out_data, push, fifo_pop);
    end
    checks++; if (idle !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_stall_flags: got idle=%b err=%b expected 0/0", idle, err); end
    reset = 1'b1;
    tick();
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL rst_reboot_init: got %b expected 0", idle); end
    tick();
    checks++; if (idle !== 1'b1 || hold !== 4'b0000) begin errors++; $display("FAIL rst_reboot_idle: got idle=%b hold=%b expected 1/0000", idle, hold); end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_pause();
    test_simultaneous();
    test_error();
    test_reset_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
